// File: rtl/bitstream_frame_reader_if.sv
// rtl/bitstream_frame_reader_if.sv - stream interface carrying the configuration bitstream
interface axi_stream_if #(
  parameter int W = 1
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bitstream_frame_reader.sv
// rtl/bitstream_frame_reader.sv - captures a fixed-length frame of beats into a register with tlast checking
module bitstream_frame_reader #(
  parameter int NUM_BITS_TO_READ = 64,
  parameter int BEAT_W           = 1,
  parameter bit CHECK_TLAST      = 1'b1,
  parameter bit MSB_FIRST        = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  axi_stream_if.slave                 bitstream,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [NUM_BITS_TO_READ-1:0] bits
);

  localparam int NUM_BEATS = NUM_BITS_TO_READ / BEAT_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  generate
    if (BEAT_W < 1 || BEAT_W > NUM_BITS_TO_READ) begin : g_bad_beat_w
      $error("BEAT_W must lie in 1..NUM_BITS_TO_READ");
    end
    if ((NUM_BITS_TO_READ % BEAT_W) != 0) begin : g_bad_multiple
      $error("NUM_BITS_TO_READ must be a multiple of BEAT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             tready;
  logic             handshake;
  logic             final_beat;

  // Lowest bit position of beat k inside the frame register.
  function automatic int slice_lo(input int k);
    if (MSB_FIRST) begin
      return NUM_BITS_TO_READ - (k + 1) * BEAT_W;
    end
    return k * BEAT_W;
  endfunction

  assign bitstream.tready = tready;
  assign handshake        = bitstream.tvalid && tready;
  assign final_beat       = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (handshake) begin
          if (!final_beat) begin
            if (CHECK_TLAST && bitstream.tlast) begin
              state_nxt = S_ERROR;
            end
          end else if (CHECK_TLAST && !bitstream.tlast) begin
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (handshake && bitstream.tlast) begin
          state_nxt = S_ERROR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // abort masks tready in the same cycle so the source keeps its pending beat.
  always_comb begin
    tready = 1'b0;
    done   = 1'b0;
    error  = 1'b0;
    case (state)
      S_READ, S_DRAIN: tready = !abort;
      S_DONE:          done   = 1'b1;
      S_ERROR:         error  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits     <= '0;
      beat_cnt <= '0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bits     <= '0;
            beat_cnt <= '0;
            err_code <= ERR_NONE;
          end
        end
        S_READ: begin
          if (abort) begin
            err_code <= ERR_ABORT;
          end else if (handshake) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
              if (beat_cnt == CNT_W'(k)) begin
                bits[slice_lo(k) +: BEAT_W] <= bitstream.tdata;
              end
            end
            if (!final_beat) begin
              if (CHECK_TLAST && bitstream.tlast) begin
                err_code <= ERR_SHORT;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end else if (CHECK_TLAST && !bitstream.tlast) begin
              err_code <= ERR_LONG;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            err_code <= ERR_ABORT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_frame_reader.sv
// tb/tb_bitstream_frame_reader.sv - scoreboard bench over four reader configurations
module tb_bitstream_frame_reader;

  logic       clk;
  logic       rst_n;
  logic       start    [4];
  logic       abort    [4];
  logic [1:0] tdata    [4];
  logic       tvalid   [4];
  logic       tlast    [4];
  logic       tready   [4];
  logic       done_w   [4];
  logic       error_w  [4];
  logic [1:0] code_w   [4];
  logic [7:0] bits_w   [4];
  logic [0:0] bits_one;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         d;
    bit         is_done;
    logic [7:0] b;
    logic [1:0] c;
    int         cy;
  } exp_t;

  exp_t sb[$];

  axi_stream_if #(.W(2)) s0 ();
  axi_stream_if #(.W(2)) s1 ();
  axi_stream_if #(.W(2)) s2 ();
  axi_stream_if #(.W(1)) s3 ();

  assign s0.tdata = tdata[0];  assign s0.tvalid = tvalid[0];  assign s0.tlast = tlast[0];
  assign s1.tdata = tdata[1];  assign s1.tvalid = tvalid[1];  assign s1.tlast = tlast[1];
  assign s2.tdata = tdata[2];  assign s2.tvalid = tvalid[2];  assign s2.tlast = tlast[2];
  assign s3.tdata = tdata[3][0:0]; assign s3.tvalid = tvalid[3]; assign s3.tlast = tlast[3];
  assign tready[0] = s0.tready;
  assign tready[1] = s1.tready;
  assign tready[2] = s2.tready;
  assign tready[3] = s3.tready;
  assign bits_w[3] = {7'b0, bits_one};

  bitstream_frame_reader #(.NUM_BITS_TO_READ(8), .BEAT_W(2), .CHECK_TLAST(1'b1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .bitstream(s0),
    .done(done_w[0]), .error(error_w[0]), .err_code(code_w[0]), .bits(bits_w[0]));
  bitstream_frame_reader #(.NUM_BITS_TO_READ(8), .BEAT_W(2), .CHECK_TLAST(1'b1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .bitstream(s1),
    .done(done_w[1]), .error(error_w[1]), .err_code(code_w[1]), .bits(bits_w[1]));
  bitstream_frame_reader #(.NUM_BITS_TO_READ(8), .BEAT_W(2), .CHECK_TLAST(1'b0), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .bitstream(s2),
    .done(done_w[2]), .error(error_w[2]), .err_code(code_w[2]), .bits(bits_w[2]));
  bitstream_frame_reader #(.NUM_BITS_TO_READ(1), .BEAT_W(1), .CHECK_TLAST(1'b1), .MSB_FIRST(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .bitstream(s3),
    .done(done_w[3]), .error(error_w[3]), .err_code(code_w[3]), .bits(bits_one));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/error pulse must match the oldest expected event.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (done_w[d] || error_w[d]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: dut %0d done=%0b error=%0b, expected no pulse", d, done_w[d], error_w[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_dut", d, e.d);
          check("pulse_is_done", done_w[d], e.is_done);
          check("pulse_is_error", error_w[d], !e.is_done);
          check("pulse_bits", bits_w[d], e.b);
          check("pulse_err_code", code_w[d], e.c);
          check("pulse_cycle", cyc, e.cy);
        end
      end
    end
  end

  task automatic push(input int d, input bit is_done, input logic [7:0] b, input logic [1:0] c, input int cy);
    exp_t e;
    e.d = d; e.is_done = is_done; e.b = b; e.c = c; e.cy = cy;
    sb.push_back(e);
  endtask

  task automatic start_frame(input int d);
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  // Drives one beat after gap idle cycles; returns the negedge cycle the handshake was seen.
  task automatic send(input int d, input logic [1:0] data, input bit last, input int gap, output int hs_cyc);
    bit got;
    tvalid[d] = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("tready_in_gap", tready[d], 1'b1);
      @(posedge clk); #1;
    end
    tvalid[d] = 1'b1;
    tdata[d]  = data;
    tlast[d]  = last;
    got = 1'b0;
    hs_cyc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (tready[d]) begin
        got = 1'b1;
        hs_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!got) check("handshake_timeout", 0, 1);
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
  endtask

  task automatic wait_sb_empty();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      check("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    int gaps[4];
    logic [1:0] beats[4];
    for (int d = 0; d < 4; d++) begin
      start[d] = 0; abort[d] = 0; tdata[d] = 0; tvalid[d] = 0; tlast[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("reset_done", done_w[d], 1'b0);
      check("reset_error", error_w[d], 1'b0);
      check("reset_err_code", code_w[d], 2'd0);
      check("reset_bits", bits_w[d], 8'h00);
      check("reset_tready", tready[d], 1'b0);
    end

    // Nominal LSB-first frame, then start during DONE must be ignored.
    beats[0] = 2'b01; beats[1] = 2'b10; beats[2] = 2'b11; beats[3] = 2'b00;
    start_frame(0);
    for (int k = 0; k < 4; k++) send(0, beats[k], k == 3, 0, hs);
    push(0, 1'b1, 8'h39, 2'd0, hs + 1);
    start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    @(negedge clk);
    check("turnaround_start_ignored", tready[0], 1'b0);
    wait_sb_empty();

    // MSB-first with idle gaps between beats.
    gaps[0] = 1; gaps[1] = 3; gaps[2] = 0; gaps[3] = 2;
    start_frame(1);
    for (int k = 0; k < 4; k++) send(1, beats[k], k == 3, gaps[k], hs);
    push(1, 1'b1, 8'h6C, 2'd0, hs + 1);
    wait_sb_empty();

    // Short frame: tlast on the second beat.
    start_frame(0);
    send(0, 2'b01, 1'b0, 0, hs);
    send(0, 2'b10, 1'b1, 0, hs);
    push(0, 1'b0, 8'h09, 2'd1, hs + 1);
    wait_sb_empty();
    @(negedge clk);
    check("short_tready_idle", tready[0], 1'b0);
    check("short_err_code_held", code_w[0], 2'd1);

    // Long frame: two extra beats drained before the error.
    start_frame(0);
    for (int k = 0; k < 4; k++) send(0, beats[k], 1'b0, 0, hs);
    send(0, 2'b11, 1'b0, 0, hs);
    send(0, 2'b01, 1'b1, 0, hs);
    push(0, 1'b0, 8'h39, 2'd2, hs + 1);
    wait_sb_empty();

    // Same stimulus with tlast ignored: done after four beats, no extra beats taken.
    start_frame(2);
    for (int k = 0; k < 4; k++) send(2, beats[k], 1'b0, 0, hs);
    push(2, 1'b1, 8'h39, 2'd0, hs + 1);
    tvalid[2] = 1'b1;
    tdata[2]  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tlast[2] = (i == 2);
      @(negedge clk);
      check("nochk_extra_tready", tready[2], 1'b0);
      @(posedge clk); #1;
    end
    tvalid[2] = 1'b0;
    tlast[2]  = 1'b0;
    wait_sb_empty();

    // Abort with a pending beat, then a clean frame.
    start_frame(0);
    send(0, 2'b01, 1'b0, 0, hs);
    send(0, 2'b10, 1'b0, 0, hs);
    tvalid[0] = 1'b1;
    tdata[0]  = 2'b11;
    abort[0]  = 1'b1;
    @(negedge clk);
    check("abort_tready", tready[0], 1'b0);
    @(posedge clk); #1;
    abort[0]  = 1'b0;
    @(negedge clk);
    check("abort_err_code", code_w[0], 2'd3);
    check("abort_idle_tready", tready[0], 1'b0);
    @(posedge clk); #1;
    tvalid[0] = 1'b0;
    start_frame(0);
    send(0, 2'b11, 1'b0, 0, hs);
    send(0, 2'b00, 1'b0, 0, hs);
    send(0, 2'b01, 1'b0, 0, hs);
    send(0, 2'b10, 1'b1, 0, hs);
    push(0, 1'b1, 8'h93, 2'd0, hs + 1);
    wait_sb_empty();

    // Reset mid-frame after three beats.
    start_frame(0);
    for (int k = 0; k < 3; k++) send(0, beats[k], 1'b0, 0, hs);
    tvalid[0] = 1'b1;
    tdata[0]  = 2'b00;
    tlast[0]  = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    tvalid[0] = 1'b0;
    tlast[0]  = 1'b0;
    @(negedge clk);
    check("midreset_bits", bits_w[0], 8'h00);
    check("midreset_err_code", code_w[0], 2'd0);
    check("midreset_done", done_w[0], 1'b0);
    check("midreset_error", error_w[0], 1'b0);
    check("midreset_tready", tready[0], 1'b0);
    start_frame(0);
    send(0, 2'b10, 1'b0, 0, hs);
    send(0, 2'b01, 1'b0, 0, hs);
    send(0, 2'b00, 1'b0, 0, hs);
    send(0, 2'b11, 1'b1, 0, hs);
    push(0, 1'b1, 8'hC6, 2'd0, hs + 1);
    wait_sb_empty();

    // Degenerate single-bit frame.
    start_frame(3);
    send(3, 2'b01, 1'b1, 0, hs);
    push(3, 1'b1, 8'h01, 2'd0, hs + 1);
    wait_sb_empty();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
